mips_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit for the multicycle MIPS core. It generalises the single-cycle

---
 rtl/mips_muldiv_unit_pkg.sv | 38 +++
 rtl/md_negate.sv | 18 +
 rtl/mips_muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mips_muldiv_unit_pkg
//  Purpose  : Op codes, FSM state encoding and MIPS funct codes shared by the
//             multiply/divide unit and the controller.
//  Revision : 1.0  initial release
// ============================================================================
package mips_muldiv_unit_pkg;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_negate.sv
`default_nettype none
// ============================================================================
//  Module   : md_negate
//  Purpose  : Conditional two's-complement negate (combinational).
//  Revision : 1.0  initial release
// ============================================================================
module md_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mips_muldiv_unit
//  Purpose  : Radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO results.
//  Revision : 1.0  initial release
// ============================================================================
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    import mips_muldiv_unit_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_int_q, dz_int_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               w_a_neg, w_b_neg, w_accept;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh, w_rem_sub;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic               w_unused;

    assign w_a_neg  = op_is_signed(op) & a[WIDTH-1];
    assign w_b_neg  = op_is_signed(op) & b[WIDTH-1];
    // The cycle after done is still busy, so it cannot accept a new start.
    assign w_accept = start && (state_q == MD_IDLE) && !busy_q;

    md_negate #(.WIDTH(WIDTH)) u_abs_a (.neg(w_a_neg), .din(a), .dout(w_abs_a));
    md_negate #(.WIDTH(WIDTH)) u_abs_b (.neg(w_b_neg), .din(b), .dout(w_abs_b));

    md_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg (neg_res_q),
        .din ({acc_hi_q, acc_lo_q}),
        .dout(w_prod_fix)
    );
    md_negate #(.WIDTH(WIDTH)) u_fix_quo (.neg(neg_res_q), .din(acc_lo_q), .dout(w_quo_fix));
    md_negate #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_rem_q), .din(acc_hi_q), .dout(w_rem_fix));

    // Multiply step: carry of the add shifts into the top of P.
    assign w_mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

    // Restoring divide step on the left-shifted {R,Q}.
    assign w_rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, opnd_q};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, opnd_q});
    assign w_unused  = w_rem_sub[WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_int_d   = dz_int_q;
        opnd_d     = opnd_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            MD_IDLE: begin
                if (w_accept) begin
                    is_div_d   = op_is_div(op);
                    neg_res_d  = w_a_neg ^ w_b_neg;
                    neg_rem_d  = w_a_neg;
                    cnt_d      = CNT_W'(WIDTH);
                    div_zero_d = 1'b0;
                    if (op_is_div(op) && (b == '0)) begin
                        acc_hi_d = a;
                        acc_lo_d = '1;
                        dz_int_d = 1'b1;
                        state_d  = MD_DONE;
                    end else begin
                        dz_int_d = 1'b0;
                        acc_hi_d = '0;
                        acc_lo_d = op_is_div(op) ? w_abs_a : w_abs_b;
                        opnd_d   = op_is_div(op) ? w_abs_b : w_abs_a;
                        state_d  = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div_q) begin
                    acc_hi_d = w_rem_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], w_rem_ge};
                end else begin
                    acc_hi_d = w_mul_sum[WIDTH:1];
                    acc_lo_d = {w_mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                if (is_div_q) begin
                    acc_hi_d = w_rem_fix;
                    acc_lo_d = w_quo_fix;
                end else begin
                    {acc_hi_d, acc_lo_d} = w_prod_fix;
                end
                state_d = MD_DONE;
            end
            MD_DONE: begin
                hi_d       = acc_hi_q;
                lo_d       = acc_lo_q;
                div_zero_d = dz_int_q;
                state_d    = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase

        busy_d = (state_d != MD_IDLE) || (state_q == MD_DONE);
        done_d = (state_q == MD_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_int_q   <= 1'b0;
            opnd_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_int_q   <= dz_int_d;
            opnd_q     <= opnd_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_muldiv_unit
//  Purpose  : Self-checking bench for a 32-bit and an 8-bit mips_muldiv_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_muldiv_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    logic        CLK;
    logic        RST;
    logic        start_i [2];
    logic [1:0]  op_i    [2];
    logic [31:0] a_i     [2];
    logic [31:0] b_i     [2];
    logic        d_busy  [2];
    logic        d_done  [2];
    logic        d_dz    [2];
    logic [31:0] d_hi    [2];
    logic [31:0] d_lo    [2];
    logic [7:0]  hi8, lo8;

    logic        m_busy  [2];
    logic        m_done  [2];
    logic        m_dz    [2];
    logic [31:0] m_hi    [2];
    logic [31:0] m_lo    [2];
    int          m_rem   [2];
    res_t        p_res   [2];

    int n_checks = 0;
    int n_pass   = 0;

    mips_muldiv_unit #(.WIDTH(32)) u_dut32 (
        .CLK(CLK), .RST(RST), .start(start_i[0]), .op(op_i[0]),
        .a(a_i[0]), .b(b_i[0]), .busy(d_busy[0]), .done(d_done[0]),
        .hi(d_hi[0]), .lo(d_lo[0]), .div_zero(d_dz[0])
    );

    mips_muldiv_unit #(.WIDTH(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .start(start_i[1]), .op(op_i[1]),
        .a(a_i[1][7:0]), .b(b_i[1][7:0]), .busy(d_busy[1]), .done(d_done[1]),
        .hi(hi8), .lo(lo8), .div_zero(d_dz[1])
    );

    assign d_hi[1] = {24'd0, hi8};
    assign d_lo[1] = {24'd0, lo8};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int wid(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    // Reference result straight from the arithmetic definition of each op.
    function automatic res_t ref_calc(input int w, input logic [1:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ua, ub, up;
        longint          sa, sb, sp;
        res_t            r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = $signed(ua);
        sb   = $signed(ub);
        if (((ua >> (w - 1)) & 64'd1) != 0) sa = sa - $signed(64'd1 << w);
        if (((ub >> (w - 1)) & 64'd1) != 0) sb = sb - $signed(64'd1 << w);
        r = '0;
        if (op == 2'b00) begin
            up   = ua * ub;
            r.hi = 32'((up >> w) & mask);
            r.lo = 32'(up & mask);
        end else if (op == 2'b01) begin
            sp   = sa * sb;
            up   = $unsigned(sp);
            r.hi = 32'((up >> w) & mask);
            r.lo = 32'(up & mask);
        end else if (ub == 0) begin
            r.hi = 32'(ua);
            r.lo = 32'(mask);
            r.dz = 1'b1;
        end else if (op == 2'b10) begin
            r.lo = 32'(ua / ub);
            r.hi = 32'(ua % ub);
        end else begin
            sp   = sa / sb;
            r.lo = 32'($unsigned(sp) & mask);
            sp   = sa % sb;
            r.hi = 32'($unsigned(sp) & mask);
        end
        return r;
    endfunction

    function automatic int lat_of(input int w, input logic [1:0] op, input logic [31:0] b);
        longint unsigned mask;
        logic            is_div;
        mask   = (64'd1 << w) - 64'd1;
        is_div = op[1];
        return (is_div && (({32'd0, b} & mask) == 0)) ? 1 : w + 2;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = 32'((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return m;
            3:       return 32'(64'd1 << (w - 1));
            default: return $urandom & m;
        endcase
    endfunction

    // Transaction-level model: idle -> busy for a fixed latency -> one done cycle.
    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_dz[i]   <= 1'b0;
                m_hi[i]   <= '0;
                m_lo[i]   <= '0;
                m_rem[i]  <= 0;
            end else if (m_done[i]) begin
                m_done[i] <= 1'b0;
                m_busy[i] <= 1'b0;
            end else if (m_busy[i]) begin
                m_rem[i] <= m_rem[i] - 1;
                if (m_rem[i] == 1) begin
                    m_done[i] <= 1'b1;
                    m_hi[i]   <= p_res[i].hi;
                    m_lo[i]   <= p_res[i].lo;
                    m_dz[i]   <= p_res[i].dz;
                end
            end else if (start_i[i]) begin
                m_busy[i] <= 1'b1;
                m_dz[i]   <= 1'b0;
                p_res[i]  <= ref_calc(wid(i), op_i[i], a_i[i], b_i[i]);
                m_rem[i]  <= lat_of(wid(i), op_i[i], b_i[i]);
            end
        end
    end

    task automatic check(input logic ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                check({d_busy[i], d_done[i], d_dz[i], d_hi[i], d_lo[i]} ===
                      {m_busy[i], m_done[i], m_dz[i], m_hi[i], m_lo[i]},
                      (i == 0) ? "cycle_model_w32" : "cycle_model_w8",
                      {d_busy[i], d_done[i], d_dz[i], d_hi[i], d_lo[i]},
                      {m_busy[i], m_done[i], m_dz[i], m_hi[i], m_lo[i]});
            end
        end
    endtask

    task automatic wait_idle(input int i);
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (!d_busy[i]) return;
        end
        check(1'b0, "idle_timeout", {31'd0, d_busy[i]}, 128'd0);
    endtask

    task automatic run_op(input int i, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz,
                          input int exp_lat, input string name);
        int   lat;
        logic busy_ok;
        wait_idle(i);
        start_i[i] = 1'b1;
        op_i[i]    = op;
        a_i[i]     = a;
        b_i[i]     = b;
        @(posedge CLK);
        #1;
        start_i[i] = 1'b0;
        busy_ok    = d_busy[i];
        lat        = 0;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            @(posedge CLK);
            #1;
            if (!d_busy[i]) busy_ok = 1'b0;
            if (d_done[i]) lat = k;
        end
        check(lat == exp_lat, {name, "_latency"}, lat, exp_lat);
        check(busy_ok, {name, "_busy"}, {127'd0, busy_ok}, 128'd1);
        check(d_hi[i] === exp_hi, {name, "_hi"}, d_hi[i], exp_hi);
        check(d_lo[i] === exp_lo, {name, "_lo"}, d_lo[i], exp_lo);
        check(d_dz[i] === exp_dz, {name, "_div_zero"}, d_dz[i], exp_dz);
    endtask

    initial begin
        int          nd;
        logic [31:0] h4, l4;
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0;
            op_i[i]    = 2'b00;
            a_i[i]     = '0;
            b_i[i]     = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            check({d_busy[i], d_done[i], d_dz[i], d_hi[i], d_lo[i]} === '0, "reset_state",
                  {d_busy[i], d_done[i], d_dz[i], d_hi[i], d_lo[i]}, 128'd0);
        end
        @(negedge CLK);
        RST = 1'b0;
        fork
            compare_loop();
        join_none

        run_op(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, "multu_max");
        run_op(0, 2'b01, 32'hFFFFFFFA, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 34, "mult_neg");
        run_op(0, 2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, "div_neg");
        run_op(0, 2'b10, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 1,  "divu_zero");
        run_op(0, 2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, "divu_after_zero");

        // Overflow divide with a second start pulsed mid-CALC.
        wait_idle(0);
        start_i[0] = 1'b1;
        op_i[0]    = 2'b11;
        a_i[0]     = 32'h80000000;
        b_i[0]     = 32'hFFFFFFFF;
        @(posedge CLK);
        #1;
        start_i[0] = 1'b0;
        nd = 0;
        h4 = '1;
        l4 = '1;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK);
            #1;
            if (k == 5) begin
                start_i[0] = 1'b1;
                op_i[0]    = 2'b00;
                a_i[0]     = 32'd3;
                b_i[0]     = 32'd3;
            end
            if (k == 6) start_i[0] = 1'b0;
            if (d_done[0]) begin
                nd++;
                h4 = d_hi[0];
                l4 = d_lo[0];
            end
        end
        check(nd == 1, "div_ovf_single_done", nd, 1);
        check(h4 === 32'h0, "div_ovf_hi", h4, 32'h0);
        check(l4 === 32'h80000000, "div_ovf_lo", l4, 32'h80000000);

        // Asynchronous reset in the middle of an operation.
        wait_idle(0);
        start_i[0] = 1'b1;
        op_i[0]    = 2'b00;
        a_i[0]     = 32'h12345678;
        b_i[0]     = 32'h9ABCDEF1;
        @(posedge CLK);
        #1;
        start_i[0] = 1'b0;
        repeat (10) @(posedge CLK);
        #3;
        check(d_busy[0] === 1'b1, "busy_mid_calc", {127'd0, d_busy[0]}, 128'd1);
        RST = 1'b1;
        #1;
        check({d_busy[0], d_done[0], d_hi[0], d_lo[0]} === '0, "async_reset_clears",
              {d_busy[0], d_done[0], d_hi[0], d_lo[0]}, 128'd0);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        run_op(0, 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34, "multu_after_reset");

        run_op(1, 2'b01, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, 10, "w8_mult_min");
        run_op(1, 2'b10, 32'hFF, 32'h10, 32'h0F, 32'h0F, 1'b0, 10, "w8_divu");

        // Random traffic on both instances, including starts while busy.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                start_i[i] = ($urandom_range(0, 3) == 0);
                op_i[i]    = 2'($urandom_range(0, 3));
                a_i[i]     = pick(wid(i));
                b_i[i]     = pick(wid(i));
            end
        end
        @(negedge CLK);
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        repeat (50) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
